// File: rtl/mul_acc_unit.sv
// Sequential unsigned multiply-accumulate: res = opr1*opr2 + add at 2*WIDTH bits.
// Radix-2 shift-add datapath with fixed WIDTH-cycle latency, controlled by an IDLE/BUSY/DONE FSM.
module mul_acc_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] opr1_i,
  input  logic [WIDTH-1:0] opr2_i,
  input  logic [WIDTH-1:0] add_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               last_step;

  // Partial sums never exceed the final result, so 2*WIDTH bits cannot overflow.
  always_comb begin
    acc_step = acc;
    if (mplier[0]) acc_step = acc + mcand;
  end

  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == BUSY);
  assign done_o = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      res_hi_o <= '0;
      res_lo_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            mcand  <= {{WIDTH{1'b0}}, opr1_i};
            mplier <= opr2_i;
            acc    <= {{WIDTH{1'b0}}, add_i};
            cnt    <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // Result registers only change on entry to DONE and hold until the next one.
          if (last_step) begin
            res_hi_o <= acc_step[2*WIDTH-1:WIDTH];
            res_lo_o <= acc_step[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_acc_unit.sv
// Directed bench for mul_acc_unit: vector table through the full latency plus
// hand-written reset-abort and held-start back-to-back sequences.
module tb_mul_acc_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] opr1, opr2, add;
  logic         busy, done;
  logic [W-1:0] res_hi, res_lo;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_hi, prev_lo;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[9];

  mul_acc_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .opr1_i   (opr1),
    .opr2_i   (opr2),
    .add_i    (add),
    .busy_o   (busy),
    .done_o   (done),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One complete operation: accept edge k, then edges k+1..k+W, then the return to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input bit rel_rst, input string name);
    int bad_busy;
    @(negedge clk);
    if (rel_rst) rst = 1'b0;
    opr1 = a; opr2 = b; add = c; start = 1'b1;
    @(posedge clk); #1;
    chk({name, " busy_after_accept"}, {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    opr1 = $urandom; opr2 = $urandom; add = $urandom;
    bad_busy = 0;
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      if (i < W) begin
        if (done || !busy) bad_busy++;
        if (i == W / 2) begin
          chk({name, " res_held_hi"}, {32'd0, res_hi}, {32'd0, prev_hi});
          chk({name, " res_held_lo"}, {32'd0, res_lo}, {32'd0, prev_lo});
        end
      end else begin
        chk({name, " busy_window"}, 64'(bad_busy), 64'd0);
        chk({name, " done"}, {62'd0, done, busy}, 64'd2);
        chk({name, " res_hi"}, {32'd0, res_hi}, {32'd0, eh});
        chk({name, " res_lo"}, {32'd0, res_lo}, {32'd0, el});
      end
    end
    @(posedge clk); #1;
    chk({name, " idle_after"}, {62'd0, done, busy}, 64'd0);
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    int n_done;
    int r;
    int done_at[$];
    logic [63:0] res_at[$];

    vecs[0] = '{32'd2,          32'd3,          32'd2,          32'h0,        32'h8};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h0};
    vecs[2] = '{32'h0,          32'h1234,       32'd5,          32'h0,        32'h5};
    vecs[3] = '{32'h10000,      32'h10000,      32'h0,          32'h1,        32'h0};
    vecs[4] = '{32'h12345678,   32'h0,          32'hFFFFFFFF,   32'h0,        32'hFFFFFFFF};
    vecs[5] = '{32'h80000000,   32'd2,          32'd1,          32'h1,        32'h1};
    vecs[6] = '{32'hFFFFFFFF,   32'd2,          32'h0,          32'h1,        32'hFFFFFFFE};
    vecs[7] = '{32'h1000,       32'h1000,       32'h10,         32'h0,        32'h01000010};
    vecs[8] = '{32'h0,          32'h0,          32'h0,          32'h0,        32'h0};

    rst = 1'b1; start = 1'b0; opr1 = '0; opr2 = '0; add = '0;
    prev_hi = '0; prev_lo = '0;
    #1;
    chk("reset_ctrl", {62'd0, done, busy}, 64'd0);
    chk("reset_res", {res_hi, res_lo}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 9; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].hi, vecs[v].lo, 1'b0, $sformatf("vec%0d", v));

    // Reset ten cycles into BUSY: everything clears at once and no done pulse follows.
    @(negedge clk);
    opr1 = 32'h55; opr2 = 32'h66; add = 32'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ctrl", {62'd0, done, busy}, 64'd0);
    chk("abort_res", {res_hi, res_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);

    // Start on the first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    prev_hi = '0; prev_lo = '0;
    run_op(32'd7, 32'd6, 32'd1, 32'h0, 32'd43, 1'b1, "post_reset");

    // start held high across three operations with operands changed mid-BUSY.
    @(negedge clk);
    opr1 = 32'd3; opr2 = 32'd5; add = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    r = 0;
    while (r < 110) begin
      @(negedge clk);
      if (r == 10) begin opr1 = 32'hFFFF; opr2 = 32'hFFFF; add = 32'd1; end
      if (r == 44) begin opr1 = 32'd100;  opr2 = 32'd100;  add = 32'd0; end
      if (r == 70) start = 1'b0;
      @(posedge clk); #1;
      r++;
      if (done) begin
        done_at.push_back(r);
        res_at.push_back({res_hi, res_lo});
      end
    end
    chk("b2b_count", 64'(done_at.size()), 64'd3);
    if (done_at.size() == 3) begin
      chk("b2b_t0", 64'(done_at[0]), 64'd32);
      chk("b2b_gap1", 64'(done_at[1] - done_at[0]), 64'd34);
      chk("b2b_gap2", 64'(done_at[2] - done_at[1]), 64'd34);
      chk("b2b_res0", res_at[0], 64'd22);
      chk("b2b_res1", res_at[1], 64'hFFFE0002);
      chk("b2b_res2", res_at[2], 64'd10000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_acc_unit.md
MUL_ACC_UNIT -- requirements
Module: mul_acc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request to start an operation; sampled only in IDLE.
REQ-005 SHALL have port opr1_i  input  WIDTH  multiplicand (quotient side), unsigned.
REQ-006 SHALL have port opr2_i  input  WIDTH  multiplier (divisor side), unsigned.
REQ-007 SHALL have port add_i  input  WIDTH  addend (remainder side), unsigned.
REQ-008 SHALL have port busy_o  output  1  high while an operation is in progress.
REQ-009 SHALL have port done_o  output  1  single-cycle pulse when the result becomes valid.
REQ-010 SHALL have port res_hi_o  output  WIDTH  upper WIDTH bits of opr1*opr2+add.
REQ-011 SHALL have port res_lo_o  output  WIDTH  lower WIDTH bits of opr1*opr2+add.

Function
REQ-012 SHALL compute the unsigned result opr1_i*opr2_i+add_i at 2*WIDTH bits, with no overflow and no truncation.
REQ-013 SHALL implement the three-state FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 SHALL, in IDLE with start_i=1, register opr1_i, opr2_i and add_i at that edge (edge k), initialise the accumulator to zero-extended add_i, and enter BUSY.
REQ-015 SHALL ignore the operand inputs at every edge other than the accepting edge; operand changes during BUSY SHALL NOT affect the result.
REQ-016 SHALL, in BUSY, perform one radix-2 shift-add step per cycle, for exactly WIDTH steps, counted by an iteration counter.
REQ-016a SHALL, on each step, add the shifted multiplicand to the accumulator if the current multiplier bit is 1.
REQ-016b SHALL, on each step, shift the multiplicand left by 1 and the multiplier right by 1.
REQ-017 SHALL keep a fixed latency with no early termination: after edge k+WIDTH the FSM SHALL be in DONE, done_o=1 and res_hi_o/res_lo_o valid.
REQ-018 SHALL hold done_o high for exactly one cycle, then return to IDLE at edge k+WIDTH+1.
REQ-019 SHALL hold busy_o=1 from after edge k through edge k+WIDTH (BUSY state only) and 0 in IDLE and DONE.
REQ-020 SHALL update res_hi_o/res_lo_o only on the transition into DONE, and hold them stable until the next transition into DONE or reset.
REQ-021 SHALL ignore start_i in BUSY and DONE; a start_i held high SHALL be accepted at the first IDLE edge, giving one operation every WIDTH+2 cycles.
REQ-022 SHALL treat zero operands like any other value: full latency, correct result (e.g. result = add_i when either factor is 0).

Reset
REQ-023 SHALL, on rst=1 and independent of clk, immediately force the FSM to IDLE and clear busy_o, done_o, res_hi_o, res_lo_o, the accumulator, the operand registers and the iteration counter to 0.
REQ-024 SHALL, on reset mid-operation (BUSY or DONE), abort the operation with no done_o pulse and clear any result.
REQ-025 SHALL accept start_i at the first rising edge after rst deasserts.

Verification
REQ-026 SHALL cover: opr1=2, opr2=3, add=2, start at edge k -> done_o=1 after edge k+32 only, res_hi=0x0, res_lo=0x8, busy_o low after edge k+32.
REQ-027 SHALL cover: opr1=opr2=add=0xFFFFFFFF -> res_hi=0xFFFFFFFF, res_lo=0x00000000 (maximum value, no overflow).
REQ-028 SHALL cover: opr1=0, opr2=0x1234, add=5 -> res={0x0,0x5} after full 32-cycle latency; then opr1=0x10000, opr2=0x10000, add=0 -> res_hi=0x1, res_lo=0x0.
REQ-029 SHALL cover: rst asserted 10 cycles into BUSY -> outputs 0 immediately, no done_o pulse; new op 7*6+1 after release -> res_lo=43.
REQ-030 SHALL cover: start_i held high with operands changed mid-BUSY -> results match operands sampled at each accept edge, done_o pulses exactly 34 cycles apart.
